// File: rtl/cpu_pkg.sv
// Shared CPU constants for the fetch-side branch predictor: counter encodings,
// sequential PC step and reset PC.
package cpu_pkg;

  localparam logic [1:0]  CNT_SNT  = 2'b00;
  localparam logic [1:0]  CNT_WNT  = 2'b01;
  localparam logic [1:0]  CNT_WT   = 2'b10;
  localparam logic [1:0]  CNT_ST   = 2'b11;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, expressed as a pure next-state function
// so one instance can serve whichever table entry is being trained.
module sat_counter2
  import cpu_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_en,
  input  logic       i_up,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_en) begin
      if (i_up && (i_cnt != CNT_ST))
        o_cnt = i_cnt + 2'd1;
      else if (!i_up && (i_cnt != CNT_SNT))
        o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped direction predictor + BTB with zero-latency lookup and
// registered EX-side training. Optional counters under macro BP_STATS_EN.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_cnt_nxt;

  assign w_f_idx = fetch_pc[IDX_W+1:2];
  assign w_f_tag = fetch_pc[31:IDX_W+2];
  assign w_u_idx = upd_pc[IDX_W+1:2];
  assign w_u_tag = upd_pc[31:IDX_W+2];

  // Lookup reads registered state only, so same-cycle updates are not bypassed.
  assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign pred_taken  = !rst && w_f_hit && r_cnt[w_f_idx][1];
  assign pred_target = pred_taken ? r_target[w_f_idx] : fetch_pc + PC_STEP;

  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  sat_counter2 u_sat_counter2 (
    .i_cnt (r_cnt[w_u_idx]),
    .i_en  (1'b1),
    .i_up  (upd_taken),
    .o_cnt (w_cnt_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        r_cnt[w_u_idx] <= w_cnt_nxt;
        if (upd_taken)
          r_target[w_u_idx] <= upd_target;
      end else if (upd_taken) begin
        // Misses allocate only on taken, so an alias must win a taken branch to evict.
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_cnt[w_u_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else if (upd_valid) begin
      if (r_stat_br != 32'hFFFF_FFFF)
        r_stat_br <= r_stat_br + 32'd1;
      if (upd_mispredict && (r_stat_mp != 32'hFFFF_FFFF))
        r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;

  logic w_unused;
  assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{fetch_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direction predictor plus branch target buffer (BTB) feeding the IF stage's prediction and predicted-target inputs.
- IF presents the current fetch PC. The block returns, in the same cycle, a taken/not-taken prediction and the target PC.
- EX writes back resolved branch outcomes. These train per-entry 2-bit saturating counters and allocate or refresh BTB entries.

Parameters:
- ENTRIES, 16, number of direction-tracking and target-storage table entries; must be a power of 2, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, never overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fetch_pc  input  32  PC currently being fetched by IF.
- pred_taken  output  1  1 = fetch_pc predicted taken.
- pred_target  output  32  predicted target; drives IF's control_pc.
- upd_valid  input  1  EX resolved a branch this cycle.
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  actual outcome of the resolved branch.
- upd_target  input  32  actual target of the resolved branch.
- upd_mispredict  input  1  EX detected a misprediction; used only under BP_STATS_EN.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Per-entry state: valid (1 bit), tag, target (32 bits), cnt (2 bits).
- cnt encoding: 00 SNT, 01 WNT, 10 WT, 11 ST.
- Lookup is combinational from registered table state, zero latency:
  - hit = valid[idx] && tag[idx] == fetch_tag.
  - pred_taken = hit && cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : fetch_pc + 4.
- Reset:
  - All valid = 0, all cnt = 01 (WNT), targets = 0.
  - Outputs during reset: pred_taken = 0, pred_target = fetch_pc + 4.
  - Reset asserted mid-operation clears the table immediately; any in-flight update that cycle is dropped.
- Update, registered, when upd_valid = 1, entry selected by upd_pc:
  - Miss (invalid or tag mismatch):
    - If upd_taken = 1: allocate with valid = 1, tag written, target = upd_target, cnt = 10 (WT).
    - If upd_taken = 0: no allocation; entry untouched.
  - Hit: cnt saturating +1 if taken, −1 if not taken. Stays 11 on taken, stays 00 on not-taken.
  - Hit with upd_taken = 1: target overwritten with upd_target.
- Simultaneous lookup and update to the same index: lookup sees pre-update contents (no bypass). New state is visible the next cycle.
- Aliasing: a different tag at the same index replaces the entry only on a taken update.
- fetch_pc + 4 wraps modulo 2^32 (0xFFFFFFFC → 0x00000000).

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on every upd_valid. stat_mispredicts increments on upd_valid && upd_mispredict.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters do not exist, and upd_mispredict is unused.

Decomposition:
- Shared package cpu_pkg holds:
  - Counter encoding constants CNT_SNT/CNT_WNT/CNT_WT/CNT_ST.
  - Constant PC_STEP = 4.
  - Reset PC constant.
- One natural sub-module, sat_counter2: 2-bit saturating up/down counter with enable. Instantiated per entry, or as a pure next-state function.

Test Plan:
- After reset, fetch_pc = 0x40 → pred_taken = 0, pred_target = 0x44. fetch_pc = 0xFFFFFFFC → pred_target = 0x00000000.
- Update upd_pc = 0x40, taken, target 0x100.
  - Same cycle, fetch_pc = 0x40 → pred_taken = 0 (no bypass).
  - Next cycle → pred_taken = 1, pred_target = 0x100.
- Training on 0x40:
  - Two more taken updates → cnt = 11.
  - Two not-taken updates → cnt = 01, pred_taken = 0.
  - Third not-taken → cnt = 00, saturated.
  - Then one taken → cnt = 01, still not taken.
- Alias at index 0:
  - Not-taken update for 0x100 → 0x40 entry untouched.
  - Taken update for 0x100, target 0x200 → fetch 0x100 predicts 0x200; fetch 0x40 → pred_taken = 0.
- Assert rst asynchronously mid-cycle after training → outputs drop immediately to not-taken / pc + 4. All entries predict not-taken after release.
- BP_STATS_EN defined: 5 updates, 2 with upd_mispredict = 1 → stat_branches = 5, stat_mispredicts = 2. Reset → both 0.
